// File: rtl/test_signext.sv
// Immediate-field extender: registers sign-extended copies of 4/8/12-bit
// immediates, plus the 8-bit immediate shifted into the upper byte.
module test_signext (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  InputFour,
    input  logic [7:0]  InputEight,
    input  logic [11:0] InputTwelve,
    output logic [15:0] OutputFour,
    output logic [15:0] OutputEight,
    output logic [15:0] OutputTwelve,
    output logic [15:0] OutputUpperEight
);

    logic [15:0] fourNext;
    logic [15:0] eightNext;
    logic [15:0] twelveNext;
    logic [15:0] upperNext;

    // Each result bit is either a source bit or that source's sign bit.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : gBit
            if (gi < 4) begin : gFourLow
                assign fourNext[gi] = InputFour[gi];
            end else begin : gFourHigh
                assign fourNext[gi] = InputFour[3];
            end

            if (gi < 8) begin : gEightLow
                assign eightNext[gi] = InputEight[gi];
                assign upperNext[gi] = 1'b0;
            end else begin : gEightHigh
                assign eightNext[gi] = InputEight[7];
                assign upperNext[gi] = InputEight[gi-8];
            end

            if (gi < 12) begin : gTwelveLow
                assign twelveNext[gi] = InputTwelve[gi];
            end else begin : gTwelveHigh
                assign twelveNext[gi] = InputTwelve[11];
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            OutputFour       <= 16'h0000;
            OutputEight      <= 16'h0000;
            OutputTwelve     <= 16'h0000;
            OutputUpperEight <= 16'h0000;
        end else begin
            OutputFour       <= fourNext;
            OutputEight      <= eightNext;
            OutputTwelve     <= twelveNext;
            OutputUpperEight <= upperNext;
        end
    end

endmodule

// File: tb/tb_test_signext.sv
// Randomized bench for test_signext: arithmetic reference model compared every
// cycle, plus directed literal checks on boundaries, latency and async reset.
module tb_test_signext;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  InputFour = '0;
    logic [7:0]  InputEight = '0;
    logic [11:0] InputTwelve = '0;
    logic [15:0] OutputFour;
    logic [15:0] OutputEight;
    logic [15:0] OutputTwelve;
    logic [15:0] OutputUpperEight;

    int checks = 0;
    int passes = 0;
    logic checkEn = 1'b0;

    logic [15:0] m4, m8, m12, mU;

    test_signext dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .InputFour        (InputFour),
        .InputEight       (InputEight),
        .InputTwelve      (InputTwelve),
        .OutputFour       (OutputFour),
        .OutputEight      (OutputEight),
        .OutputTwelve     (OutputTwelve),
        .OutputUpperEight (OutputUpperEight)
    );

    always #5 CLK = ~CLK;

    // Model works on integer values: a signed argument widens to int with its sign.
    function automatic logic [15:0] low16(int v);
        return v[15:0];
    endfunction

    function automatic logic [15:0] upperOf(logic [7:0] b);
        int v;
        v = int'(b) * 256;
        return v[15:0];
    endfunction

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m4  <= 16'h0000;
            m8  <= 16'h0000;
            m12 <= 16'h0000;
            mU  <= 16'h0000;
        end else begin
            m4  <= low16($signed(InputFour));
            m8  <= low16($signed(InputEight));
            m12 <= low16($signed(InputTwelve));
            mU  <= upperOf(InputEight);
        end
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (checkEn) begin
            check16("model_four",   OutputFour,       m4);
            check16("model_eight",  OutputEight,      m8);
            check16("model_twelve", OutputTwelve,     m12);
            check16("model_upper",  OutputUpperEight, mU);
        end
    end

    // Called at posedge+1: drive inputs, wait one edge, land at posedge+1 again.
    task automatic applyClock(input logic [3:0] a, input logic [7:0] b, input logic [11:0] c);
        InputFour   = a;
        InputEight  = b;
        InputTwelve = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [15:0] e4, input logic [15:0] e8,
                            input logic [15:0] e12, input logic [15:0] eU);
        check16({tag, "_four"},   OutputFour,       e4);
        check16({tag, "_eight"},  OutputEight,      e8);
        check16({tag, "_twelve"}, OutputTwelve,     e12);
        check16({tag, "_upper"},  OutputUpperEight, eU);
        check16({tag, "_mfour"},  m4,  e4);
        check16({tag, "_meight"}, m8,  e8);
        check16({tag, "_mtwelve"}, m12, e12);
        check16({tag, "_mupper"}, mU,  eU);
    endtask

    initial begin
        #1 Reset = 1'b1;
        #1;
        check16("reset_four",   OutputFour,       16'h0000);
        check16("reset_eight",  OutputEight,      16'h0000);
        check16("reset_twelve", OutputTwelve,     16'h0000);
        check16("reset_upper",  OutputUpperEight, 16'h0000);
        InputFour = 4'hA; InputEight = 8'hAA; InputTwelve = 12'hAAA;
        @(posedge CLK); #1;
        check16("reset_hold_eight", OutputEight, 16'h0000);
        Reset = 1'b0;
        checkEn = 1'b1;

        applyClock(4'b1000, 8'h80, 12'h800);
        checkAll("neg", 16'hFFF8, 16'hFF80, 16'hF800, 16'h8000);
        applyClock(4'b0100, 8'h40, 12'h400);
        checkAll("pos", 16'h0004, 16'h0040, 16'h0400, 16'h4000);
        applyClock(4'hF, 8'hFF, 12'hFFF);
        checkAll("ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFF00);
        applyClock(4'h0, 8'h00, 12'h000);
        checkAll("zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Latency: change just after an edge, output holds until the next edge
        applyClock(4'h0, 8'h7F, 12'h000);
        InputEight = 8'h80;
        #3;
        check16("lat_hold", OutputEight, 16'h007F);
        check16("lat_indep_four", OutputFour, 16'h0000);
        @(posedge CLK); #1;
        check16("lat_update", OutputEight, 16'hFF80);
        check16("lat_upper", OutputUpperEight, 16'h8000);

        // Async reset between edges, then synchronous reload
        applyClock(4'h5, 8'h3C, 12'h9A5);
        checkAll("pre_rst", 16'h0005, 16'h003C, 16'hF9A5, 16'h3C00);
        #2 Reset = 1'b1;
        #1;
        checkAll("async_rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #4 Reset = 1'b0;
        #1;
        check16("rst_release_hold", OutputTwelve, 16'h0000);
        @(posedge CLK); #1;
        checkAll("reload", 16'h0005, 16'h003C, 16'hF9A5, 16'h3C00);

        // Randomized traffic with occasional mid-cycle reset pulses
        for (int i = 0; i < 300; i++) begin
            Reset = ($urandom_range(0, 19) == 0);
            applyClock(4'($urandom), 8'($urandom), 12'($urandom));
        end
        Reset = 1'b0;
        applyClock(4'h7, 8'h01, 12'h7FF);
        checkAll("final", 16'h0007, 16'h0001, 16'h07FF, 16'h0100);

        @(negedge CLK);
        #1;
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/test_signext.md
TEST_SIGNEXT -- requirements
Module: test_signext

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 CLK  input  1  Single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  Reset, asynchronous and active-high.
REQ-004 InputFour  input  4  4-bit two's-complement immediate.
REQ-005 InputEight  input  8  8-bit two's-complement immediate.
REQ-006 InputTwelve  input  12  12-bit two's-complement immediate.
REQ-007 OutputFour  output  16  InputFour sign-extended to 16 bits.
REQ-008 OutputEight  output  16  InputEight sign-extended to 16 bits.
REQ-009 OutputTwelve  output  16  InputTwelve sign-extended to 16 bits.
REQ-010 OutputUpperEight  output  16  InputEight placed in bits [15:8], zeros in [7:0].

Function
REQ-011 OutputFour SHALL equal {12 copies of InputFour[3], InputFour[3:0]}.
REQ-012 OutputEight SHALL equal {8 copies of InputEight[7], InputEight[7:0]}.
REQ-013 OutputTwelve SHALL equal {4 copies of InputTwelve[11], InputTwelve[11:0]}.
REQ-014 OutputUpperEight SHALL equal {InputEight[7:0], 8'b0}; no sign extension, no rounding.
REQ-015 Every output SHALL be a register loaded on each rising CLK edge from the current inputs: latency exactly 1 cycle, throughput 1 result per cycle, no enable or handshake.
REQ-016 Input and output ports SHALL be independent: a change on one input SHALL affect only the outputs derived from it, at the next rising edge.
REQ-017 Outputs SHALL hold their value between rising edges regardless of input activity.
REQ-018 Boundary values SHALL map exactly: most-negative input (MSB=1, rest 0) -> MSB-replicated high bits; all-ones input -> 16'hFFFF for the three sign-extended outputs; zero -> 16'h0000.
REQ-019 No output SHALL carry X or Z once the first post-reset rising edge with known inputs has occurred.

Reset
REQ-020 While Reset is high, all four outputs SHALL be 16'h0000 immediately, without waiting for CLK.
REQ-021 Deassertion of Reset SHALL take effect synchronously: the first rising CLK edge with Reset low SHALL load outputs from the inputs.
REQ-022 Reset asserted mid-operation SHALL clear all outputs asynchronously, discarding the previous results; inputs are ignored until Reset is low.

Verification
REQ-023 Negative boundary: InputFour=4'b1000, InputEight=8'h80, InputTwelve=12'h800, one clock -> OutputFour=16'hFFF8, OutputEight=16'hFF80, OutputTwelve=16'hF800, OutputUpperEight=16'h8000.
REQ-024 Positive: InputFour=4'b0100, InputEight=8'h40, InputTwelve=12'h400, one clock -> OutputFour=16'h0004, OutputEight=16'h0040, OutputTwelve=16'h0400, OutputUpperEight=16'h4000.
REQ-025 All-ones/zero: inputs 4'hF, 8'hFF, 12'hFFF -> 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFF00; then all zero -> all outputs 16'h0000.
REQ-026 Latency: change InputEight from 8'h7F to 8'h80 just after an edge -> OutputEight stays 16'h007F until the next rising edge, then becomes 16'hFF80.
REQ-027 Async reset: with outputs nonzero, assert Reset between clock edges -> all outputs 16'h0000 before the next edge; hold inputs, deassert Reset -> outputs reload at the first subsequent rising edge.
